lcd_pattern_gen: RTL and testbench
==================================

Name: lcd_pattern_gen

Overview:
- Parametrised successor to the fixed 800-wide LCD test-pattern top.
- Contains its own timing counters and a selectable background pattern (bit-walk bars, colour bars, grid, solid).
- Overlays N_BOX independently positioned, coloured and enabled square boxes.
- All control inputs are shadowed at frame boundaries, so a frame never tears. Sits between the key/register logic and the RGB LCD pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40; H_SYNC, 48; H_BP, 40: horizontal porches and sync width (H_TOTAL = sum = 928)
- V_ACTIVE, 480, visible lines
- V_FP, 13; V_SYNC, 3; V_BP, 29: vertical porches and sync width (V_TOTAL = 525)
- CW, 11, coordinate width (must hold H_TOTAL-1 and V_TOTAL-1)
- N_BOX, 4, number of overlay boxes
- BOX_SIZE, 40, box edge length in pixels
- GRID_PITCH, 32, grid line spacing in mode 2

Ports:
- i_rgb_clk  input  1  pixel clock
- i_rgb_rst_n  input  1  asynchronous active-low reset
- i_mode  input  2  0 bit-walk, 1 colour bars, 2 grid, 3 solid
- i_solid  input  24  colour used in mode 3
- i_box_en  input  N_BOX  per-box enable
- i_box_x  input  N_BOX*CW  box left edge, packed, box k at [k*CW +: CW]
- i_box_y  input  N_BOX*CW  box top edge, packed
- i_box_rgb  input  N_BOX*24  box colour, packed
- o_lcd_rgb  output  24  pixel data
- o_lcd_hs  output  1  hsync, active low
- o_lcd_vs  output  1  vsync, active low
- o_lcd_de  output  1  data enable
- o_lcd_clk  output  1  equals ~i_rgb_clk (combinational)
- o_frame_start  output  1  one-cycle pulse with output pixel (0,0)
- o_frame_cnt  output  16  completed-frame counter, wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync release):
  - Counters = 0; rgb = 0; de = 0; hs = vs = 1.
  - o_frame_start = 0; o_frame_cnt = 0.
  - Shadow state: mode 0, all boxes disabled.
- Counters:
  - h counts 0..H_TOTAL-1; v increments when h wraps, 0..V_TOTAL-1.
  - Active region is h < H_ACTIVE && v < V_ACTIVE (active first, then FP, sync, BP).
  - hs low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs likewise on v.
- Shadow load: on the cycle h==H_TOTAL-1 && v==V_TOTAL-1, all control inputs are copied into shadow registers. Mid-frame input changes have no visible effect until the next frame.
- Pipeline, fixed 2-cycle latency from counter to pins:
  - S1 registers background colour, box hit vector, de/hs/vs.
  - S2 registers final rgb and the delayed sync signals.
  - hs/vs/de stay aligned with rgb at all times.
- Background:
  - Mode 0: bar index b = incrementing counter, advanced every BW = H_ACTIVE/24 pixels (33 at default) and saturating at 23; colour = 24'h800000 >> b. No divider.
  - Mode 1: 8 bars of width H_ACTIVE/8 (100); colours FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; the last bar absorbs the remainder.
  - Mode 2: FFFFFF where x%GRID_PITCH==0 or y%GRID_PITCH==0, else 000000. Use a pitch counter, not a modulo operator.
  - Mode 3: shadowed i_solid.
- Boxes:
  - Hit k = en[k] && x>=bx[k] && x<=bx[k]+BOX_SIZE-1 && y>=by[k] && y<=by[k]+BOX_SIZE-1.
  - Sums are computed in CW+1 bits, so there is no wrap; boxes extending past the active area are clipped.
  - The lowest-index hit wins and replaces the background.
- Output rgb is 0 whenever delayed de = 0.
- o_frame_start is high when the pixel (0,0) data reaches the pins. o_frame_cnt increments on that same cycle.
- Reset mid-frame: everything returns to reset values immediately. The first frame after release starts at (0,0) with default shadows, so boxes are not shown until the first shadow load.

Decomposition:
- Package lcd_pkg holds:
  - typedef rgb_t (24-bit);
  - enum pattern_mode_t {PM_BITWALK, PM_BARS, PM_GRID, PM_SOLID};
  - localparam colour-bar table;
  - function sync_window(cnt, start, len).
- Sub-module lcd_timing_gen (counters, hs/vs/de, x/y, end-of-frame strobe); the pattern, overlay and pipeline logic stays in the top.

Test Plan:
- Reset, then run 2 frames in mode 0 -> hs low 48 cycles per 928-cycle line; vs low 3 lines per 525; de high 800x480 per frame; pixel x=0 is 800000, x=33 is 400000, x=799 is 000001; rgb aligned 2 cycles after de rises.
- Mode 1 -> x=0..99 FFFFFF, x=100 FFFF00, x=700..799 000000; all blanking pixels 000000.
- Box0 en, x=100, y=100, rgb FF0000; box1 en, x=120, y=110, rgb 00FF00 -> (120,110) FF0000 (priority); (139,139) FF0000; (140,140) and (155,145) 00FF00; (160,150) background.
- Change i_mode 0->3 with i_solid 123456 at line 200 -> the rest of the frame is unchanged; the next frame is all 123456.
- Box at x=780, y=470 -> clipped; no wrap artefact at x<20 or y<10; de never asserted outside 800x480.
- Assert reset at line 300 for 5 cycles -> outputs go to reset values asynchronously; o_frame_cnt = 0; first o_frame_start pulse 2 cycles after release plus 0 offset at (0,0).

Source files
------------

// File: rtl/lcd_pattern_gen_pkg.sv
// lcd_pkg: shared types, colour-bar table and sync-window helper for the LCD pattern generator.
// Rev 1.0
`default_nettype none

package lcd_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    PM_BITWALK = 2'd0,
    PM_BARS    = 2'd1,
    PM_GRID    = 2'd2,
    PM_SOLID   = 2'd3
  } pattern_mode_t;

  localparam rgb_t BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // True while cnt lies in [start, start+len-1]; the sum is widened so it cannot wrap.
  function automatic logic sync_window(input logic [15:0] cnt,
                                       input logic [15:0] start,
                                       input logic [15:0] len);
    return (cnt >= start) && ({1'b0, cnt} < ({1'b0, start} + {1'b0, len}));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_pattern_gen_if.sv
// lcd_pattern_gen_if: control bundle from the key/register logic into the pattern generator.
// Rev 1.0
`default_nettype none

interface lcd_pattern_gen_if #(
  parameter int N_BOX = 4,
  parameter int CW    = 11
);
  logic [1:0]          mode;
  logic [23:0]         solid;
  logic [N_BOX-1:0]    box_en;
  logic [N_BOX*CW-1:0] box_x;
  logic [N_BOX*CW-1:0] box_y;
  logic [N_BOX*24-1:0] box_rgb;

  modport master (output mode, solid, box_en, box_x, box_y, box_rgb);
  modport slave  (input  mode, solid, box_en, box_x, box_y, box_rgb);
endinterface

`default_nettype wire

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: h/v raster counters with raw de/hs/vs and line/frame end strobes.
// Rev 1.0
`default_nettype none

module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  assign line_end  = (h == CW'(H_TOTAL - 1));
  assign frame_end = line_end && (v == CW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= frame_end ? '0 : v + CW'(1);
    end else begin
      h <= h + CW'(1);
    end
  end

  assign de = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
  assign hs = ~sync_window(16'(h), 16'(H_ACTIVE + H_FP), 16'(H_SYNC));
  assign vs = ~sync_window(16'(v), 16'(V_ACTIVE + V_FP), 16'(V_SYNC));

endmodule

`default_nettype wire

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: parametrised LCD test-pattern source with frame-shadowed controls and box overlays.
// Rev 1.0
`default_nettype none

module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 48,
  parameter int H_BP       = 40,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 13,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 29,
  parameter int CW         = 11,
  parameter int N_BOX      = 4,
  parameter int BOX_SIZE   = 40,
  parameter int GRID_PITCH = 32
) (
  input  logic               i_rgb_clk,
  input  logic               i_rgb_rst_n,
  lcd_pattern_gen_if.slave   ctrl,
  output rgb_t               o_lcd_rgb,
  output logic               o_lcd_hs,
  output logic               o_lcd_vs,
  output logic               o_lcd_de,
  output logic               o_lcd_clk,
  output logic               o_frame_start,
  output logic [15:0]        o_frame_cnt
);

  localparam int BW   = H_ACTIVE / 24;
  localparam int BARW = H_ACTIVE / 8;
  localparam logic [CW:0] BOX_LAST = (CW+1)'(BOX_SIZE - 1);

  logic [CW-1:0] h, v;
  logic          de, hs, vs, line_end, frame_end;

  lcd_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CW(CW)
  ) u_timing (
    .clk(i_rgb_clk), .rst_n(i_rgb_rst_n),
    .h(h), .v(v), .de(de), .hs(hs), .vs(vs),
    .line_end(line_end), .frame_end(frame_end)
  );

  assign o_lcd_clk = ~i_rgb_clk;

  // Control shadows, only updated on the last counter position of a frame.
  pattern_mode_t       mode_sh;
  rgb_t                solid_sh;
  logic [N_BOX-1:0]    en_sh;
  logic [N_BOX*CW-1:0] bx_sh, by_sh;
  logic [N_BOX*24-1:0] brgb_sh;

  always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
    if (!i_rgb_rst_n) begin
      mode_sh  <= PM_BITWALK;
      solid_sh <= '0;
      en_sh    <= '0;
      bx_sh    <= '0;
      by_sh    <= '0;
      brgb_sh  <= '0;
    end else if (frame_end) begin
      mode_sh  <= pattern_mode_t'(ctrl.mode);
      solid_sh <= ctrl.solid;
      en_sh    <= ctrl.box_en;
      bx_sh    <= ctrl.box_x;
      by_sh    <= ctrl.box_y;
      brgb_sh  <= ctrl.box_rgb;
    end
  end

  // Pitch counters track h/v so bar index and grid phase need no divider.
  logic [CW-1:0] bw_cnt, cb_cnt, gx_cnt, gy_cnt;
  logic [4:0]    bw_idx;
  logic [2:0]    cb_idx;

  always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
    if (!i_rgb_rst_n) begin
      bw_cnt <= '0;
      bw_idx <= '0;
      cb_cnt <= '0;
      cb_idx <= '0;
      gx_cnt <= '0;
      gy_cnt <= '0;
    end else if (line_end) begin
      bw_cnt <= '0;
      bw_idx <= '0;
      cb_cnt <= '0;
      cb_idx <= '0;
      gx_cnt <= '0;
      if (frame_end || gy_cnt == CW'(GRID_PITCH - 1)) gy_cnt <= '0;
      else                                            gy_cnt <= gy_cnt + CW'(1);
    end else begin
      if (bw_cnt == CW'(BW - 1)) begin
        bw_cnt <= '0;
        if (bw_idx != 5'd23) bw_idx <= bw_idx + 5'd1;
      end else begin
        bw_cnt <= bw_cnt + CW'(1);
      end
      if (cb_cnt == CW'(BARW - 1)) begin
        cb_cnt <= '0;
        if (cb_idx != 3'd7) cb_idx <= cb_idx + 3'd1;
      end else begin
        cb_cnt <= cb_cnt + CW'(1);
      end
      gx_cnt <= (gx_cnt == CW'(GRID_PITCH - 1)) ? '0 : gx_cnt + CW'(1);
    end
  end

  rgb_t bg;

  always_comb begin
    bg = '0;
    case (mode_sh)
      PM_BITWALK: bg = 24'h800000 >> bw_idx;
      PM_BARS:    bg = BAR_TABLE[cb_idx];
      PM_GRID:    bg = (gx_cnt == '0 || gy_cnt == '0) ? 24'hFFFFFF : 24'h000000;
      PM_SOLID:   bg = solid_sh;
      default:    bg = '0;
    endcase
  end

  logic [N_BOX-1:0] hit;

  for (genvar k = 0; k < N_BOX; k++) begin : g_box
    logic [CW:0] bx0, by0, hx, vy;
    assign bx0 = {1'b0, bx_sh[k*CW +: CW]};
    assign by0 = {1'b0, by_sh[k*CW +: CW]};
    assign hx  = {1'b0, h};
    assign vy  = {1'b0, v};
    assign hit[k] = en_sh[k] && (hx >= bx0) && (hx <= bx0 + BOX_LAST)
                             && (vy >= by0) && (vy <= by0 + BOX_LAST);
  end

  // Stage 1
  rgb_t             bg1;
  logic [N_BOX-1:0] hit1;
  logic             de1, hs1, vs1, fs1;

  always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
    if (!i_rgb_rst_n) begin
      bg1  <= '0;
      hit1 <= '0;
      de1  <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      fs1  <= 1'b0;
    end else begin
      bg1  <= bg;
      hit1 <= hit;
      de1  <= de;
      hs1  <= hs;
      vs1  <= vs;
      fs1  <= (h == '0) && (v == '0);
    end
  end

  // Descending scan so the lowest-index box is the one left standing.
  rgb_t pick;

  always_comb begin
    pick = bg1;
    for (int k = N_BOX - 1; k >= 0; k--) begin
      if (hit1[k]) pick = brgb_sh[k*24 +: 24];
    end
  end

  // Stage 2
  always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
    if (!i_rgb_rst_n) begin
      o_lcd_rgb     <= '0;
      o_lcd_de      <= 1'b0;
      o_lcd_hs      <= 1'b1;
      o_lcd_vs      <= 1'b1;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_lcd_rgb     <= de1 ? pick : '0;
      o_lcd_de      <= de1;
      o_lcd_hs      <= hs1;
      o_lcd_vs      <= vs1;
      o_frame_start <= fs1;
      if (fs1) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: scoreboard bench on a reduced raster; a reference model predicts every output pixel.
// Rev 1.0
`default_nettype none

module tb_lcd_pattern_gen;

  localparam int HA = 48, HFP = 4, HS = 6, HBP = 4;
  localparam int VA = 30, VFP = 2, VS = 3, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int CWB = 11, NB = 4, BS = 6, GP = 8;
  localparam int BW = HA / 24, BARW = HA / 8;
  localparam logic [27:0] RST_PIX = {1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef struct packed {
    logic [27:0] pix;
    logic [15:0] x;
    logic [15:0] y;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] lcd_rgb;
  logic        lcd_hs, lcd_vs, lcd_de, lcd_clk, frame_start;
  logic [15:0] frame_cnt;

  lcd_pattern_gen_if #(.N_BOX(NB), .CW(CWB)) ctrl ();

  lcd_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CW(CWB), .N_BOX(NB), .BOX_SIZE(BS), .GRID_PITCH(GP)
  ) dut (
    .i_rgb_clk(clk), .i_rgb_rst_n(rst_n), .ctrl(ctrl),
    .o_lcd_rgb(lcd_rgb), .o_lcd_hs(lcd_hs), .o_lcd_vs(lcd_vs),
    .o_lcd_de(lcd_de), .o_lcd_clk(lcd_clk),
    .o_frame_start(frame_start), .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model state: counter position currently held by the DUT and the model's shadows.
  int          mh, mv;
  logic [1:0]  sh_mode;
  logic [23:0] sh_solid;
  logic [NB-1:0] sh_en;
  int          sh_bx [NB];
  int          sh_by [NB];
  logic [23:0] sh_rgb [NB];
  logic [15:0] exp_fcnt;
  sb_t         sbq [$];

  function automatic logic [27:0] model_pix(input int x, input int y);
    logic de, hs, vs, fs;
    logic [23:0] c;
    int b;
    de = (x < HA) && (y < VA);
    hs = !((x >= HA + HFP) && (x < HA + HFP + HS));
    vs = !((y >= VA + VFP) && (y < VA + VFP + VS));
    fs = (x == 0) && (y == 0);
    c  = 24'h0;
    if (de) begin
      case (sh_mode)
        2'd0: begin
          b = x / BW;
          if (b > 23) b = 23;
          c = 24'h800000 >> b;
        end
        2'd1: begin
          b = x / BARW;
          if (b > 7) b = 7;
          c = BARS[b];
        end
        2'd2: c = ((x % GP) == 0 || (y % GP) == 0) ? 24'hFFFFFF : 24'h000000;
        default: c = sh_solid;
      endcase
      for (int k = NB - 1; k >= 0; k--) begin
        if (sh_en[k] && x >= sh_bx[k] && x < sh_bx[k] + BS &&
            y >= sh_by[k] && y < sh_by[k] + BS)
          c = sh_rgb[k];
      end
    end
    return {fs, de, hs, vs, c};
  endfunction

  always @(negedge clk) begin
    sb_t e;
    logic [27:0] obs;
    obs = {frame_start, lcd_de, lcd_hs, lcd_vs, lcd_rgb};
    if (!rst_n) begin
      check("rst_pins", {4'h0, obs}, {4'h0, RST_PIX});
      check("rst_fcnt", {16'h0, frame_cnt}, 32'h0);
      mh = 0;
      mv = 0;
      sh_mode = 2'd0;
      sh_solid = 24'h0;
      sh_en = '0;
      for (int k = 0; k < NB; k++) begin
        sh_bx[k] = 0;
        sh_by[k] = 0;
        sh_rgb[k] = 24'h0;
      end
      exp_fcnt = 16'h0;
      sbq.delete();
      sbq.push_back('{pix: RST_PIX, x: 16'hFFFF, y: 16'hFFFF});
      sbq.push_back('{pix: RST_PIX, x: 16'hFFFF, y: 16'hFFFF});
    end else begin
      sbq.push_back('{pix: model_pix(mh, mv), x: 16'(mh), y: 16'(mv)});
      if (mh == HT - 1 && mv == VT - 1) begin
        sh_mode  = ctrl.mode;
        sh_solid = ctrl.solid;
        sh_en    = ctrl.box_en;
        for (int k = 0; k < NB; k++) begin
          sh_bx[k]  = int'(ctrl.box_x[k*CWB +: CWB]);
          sh_by[k]  = int'(ctrl.box_y[k*CWB +: CWB]);
          sh_rgb[k] = ctrl.box_rgb[k*24 +: 24];
        end
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      e = sbq.pop_front();
      if (e.pix[27]) exp_fcnt = exp_fcnt + 16'd1;
      check($sformatf("pix(%0d,%0d)", e.x, e.y), {4'h0, obs}, {4'h0, e.pix});
      check("fcnt", {16'h0, frame_cnt}, {16'h0, exp_fcnt});
    end
  end

  task automatic set_box(input int k, input logic en, input int x, input int y, input logic [23:0] rgb);
    ctrl.box_en[k] = en;
    ctrl.box_x[k*CWB +: CWB] = CWB'(x);
    ctrl.box_y[k*CWB +: CWB] = CWB'(y);
    ctrl.box_rgb[k*24 +: 24] = rgb;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * HT * VT) @(posedge clk);
    #1;
  endtask

  task automatic wait_line(input int line);
    int budget;
    budget = 2 * HT * VT;
    while (mv != line && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("wait_line", {31'h0, budget > 0}, 32'h1);
  endtask

  initial begin
    ctrl.mode    = 2'd0;
    ctrl.solid   = 24'h0;
    ctrl.box_en  = '0;
    ctrl.box_x   = '0;
    ctrl.box_y   = '0;
    ctrl.box_rgb = '0;
    // Box requested before release must stay hidden until the first shadow load.
    set_box(0, 1'b1, 20, 5, 24'hABCDEF);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_frames(2);

    ctrl.mode = 2'd1;
    ctrl.box_en = '0;
    wait_frames(1);

    ctrl.mode = 2'd2;
    set_box(0, 1'b1, 10, 10, 24'hFF0000);
    set_box(1, 1'b1, 12, 11, 24'h00FF00);
    wait_frames(1);

    wait_line(20);
    ctrl.mode  = 2'd3;
    ctrl.solid = 24'h123456;
    wait_frames(2);

    ctrl.mode = 2'd0;
    set_box(0, 1'b0, 10, 10, 24'hFF0000);
    set_box(1, 1'b0, 12, 11, 24'h00FF00);
    set_box(2, 1'b1, HA - 3, VA - 2, 24'h0F0F0F);
    set_box(3, 1'b1, 2045, 2046, 24'hF0F0F0);
    wait_frames(2);

    ctrl.mode = 2'd3;
    wait_line(20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pins", {4'h0, frame_start, lcd_de, lcd_hs, lcd_vs, lcd_rgb}, {4'h0, RST_PIX});
    check("async_rst_fcnt", {16'h0, frame_cnt}, 32'h0);
    check("lcd_clk", {31'h0, lcd_clk}, {31'h0, ~clk});
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_frames(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
